rptr_empty_fwft: RTL

Read-side pointer, empty and level logic for the dual-clock asynchronous FIFO, paired with the write-side pointer/full block. It lives entirely in the `rclk` domain and consumes the write pointer after it has been double-flop synchronized into `rclk`. It drives the Gray read pointer back to the write side and presents first-word-fall-through data with a valid/ready handshake. A 2-entry output buffer hides the one-cycle synchronous memory read latency, so sustained throughput is one word per cycle.

---
 rtl/async_fifo_pkg.sv | 21 ++
 rtl/fwft_out_buf.sv | 65 ++++++
 rtl/rptr_empty_fwft.sv | 93 +++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Gray/binary conversion helpers shared by the read-side and write-side pointer blocks.
// Both functions work on a 32-bit container; callers size-cast the result back to pointer width.
package async_fifo_pkg;

  localparam int unsigned GRAY_MAXW = 32;

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of a zero-extended code are zero, so the XOR prefix is width-independent.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < GRAY_MAXW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_out_buf.sv
// Two-entry first-word-fall-through output buffer; head entry drives the read data port.
module fwft_out_buf #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] load_data,
  input  logic                 pop,
  output logic [1:0]           occ,
  output logic [DATAWIDTH-1:0] head_data
);

  logic [DATAWIDTH-1:0] head_q, head_d;
  logic [DATAWIDTH-1:0] tail_q, tail_d;
  logic [1:0]           occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({load, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = load_data;
        else               tail_d = load_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous load and pop: shift tail forward so order is preserved.
        if (occ_q == 2'd1) begin
          head_d = load_data;
        end else begin
          head_d = tail_q;
          tail_d = load_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = head_q;

  a_no_overflow:  assert property (@(posedge rclk) disable iff (!rrst_n)
                                   !(load && !pop && occ_q == 2'd2));
  a_no_underflow: assert property (@(posedge rclk) disable iff (!rrst_n)
                                   !(pop && occ_q == 2'd0));

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty flag and level logic of the async FIFO, with a FWFT
// valid/ready output fed by a 2-entry buffer that hides the memory read latency.
module rptr_empty_fwft
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = 4,
  parameter int unsigned DATAWIDTH     = 8,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [ADDRWIDTH:0]   rq2_wptr,
  input  logic [DATAWIDTH-1:0] rdata_mem,
  output logic [ADDRWIDTH-1:0] raddr,
  output logic [ADDRWIDTH:0]   rptr,
  output logic                 rempty,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATAWIDTH-1:0] rdata,
  output logic [ADDRWIDTH+1:0] rlevel,
  output logic                 raempty
);

  localparam int unsigned PW = ADDRWIDTH + 1;
  localparam int unsigned LW = ADDRWIDTH + 2;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rgray_d;
  logic          rempty_q, rempty_d;
  logic          pend_q;
  logic [LW-1:0] rlevel_q, rlevel_d;
  logic          raempty_q, raempty_d;

  logic          pop, fetch;
  logic [1:0]    occ, occ_next;
  logic [2:0]    occ_sum;
  logic [PW-1:0] wq2_bin, mem_cnt;

  always_comb begin
    pop      = rvalid && rready;
    // Occupancy the buffer will have once the in-flight word lands and any pop retires.
    occ_sum  = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
    fetch    = !rempty_q && (occ_sum < 3'd2);
    occ_next = occ_sum[1:0];

    rbin_d   = rbin_q + PW'(fetch);
    rgray_d  = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rgray_d == rq2_wptr);

    wq2_bin  = PW'(gray2bin(32'(rq2_wptr)));
    mem_cnt  = wq2_bin - rbin_d;
    rlevel_d  = LW'(mem_cnt) + LW'(fetch) + LW'(occ_next);
    raempty_d = (rlevel_d <= LW'(AEMPTY_THRESH));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      pend_q    <= 1'b0;
      rlevel_q  <= '0;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      rempty_q  <= rempty_d;
      pend_q    <= fetch;
      rlevel_q  <= rlevel_d;
      raempty_q <= raempty_d;
    end
  end

  fwft_out_buf #(
    .DATAWIDTH (DATAWIDTH)
  ) u_out_buf (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .load      (pend_q),
    .load_data (rdata_mem),
    .pop       (pop),
    .occ       (occ),
    .head_data (rdata)
  );

  assign rvalid  = (occ != 2'd0);
  assign raddr   = rbin_q[ADDRWIDTH-1:0];
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign rlevel  = rlevel_q;
  assign raempty = raempty_q;

endmodule
